// File: rtl/conv_stream_engine.sv
// Streaming KxK multi-channel convolution with valid padding and stride 1.
// Define CONV_SATURATE_EN to clamp results; by default they wrap to DATA_WIDTH.
module conv_stream_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 3,
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 64,
  parameter int FRAC_BITS   = 14
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                          in_data,
  input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  kernel,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [DATA_WIDTH-1:0]                                   out_data,
  output logic                                                    out_last
);
  localparam int DW   = DATA_WIDTH;
  localparam int K    = KERNEL_SIZE;
  localparam int C    = CHANNELS;
  localparam int W    = IMG_WIDTH;
  localparam int H    = IMG_HEIGHT;
  localparam int NTAP = C * K * K;
  localparam int PW   = 2 * DW;
  localparam int AW   = PW + $clog2(NTAP);
  localparam int CW   = $clog2(W);
  localparam int RW   = $clog2(H);
  localparam logic [CW-1:0] COL_LAST      = CW'(W - 1);
  localparam logic [CW-1:0] COL_FIRST_OUT = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(H - 1);
  localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(K - 1);

  logic                 advance, accept, issue, frame_end;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [NTAP*DW-1:0]   kernel_q;
  logic                 win_valid_q, win_last_q;
  logic                 s1_valid_q, s1_last_q;
  logic                 out_valid_q, out_last_q;
  logic [DW-1:0]        out_data_q;
  logic signed [DW-1:0] lb_q    [C][K-1][W];
  logic signed [DW-1:0] win_q   [C][K][K];
  logic signed [DW-1:0] col_vec [C][K];
  logic signed [PW-1:0] prod_d  [NTAP];
  logic signed [PW-1:0] prod_q  [NTAP];
  logic signed [AW-1:0] acc;
  logic [DW-1:0]        result;
`ifdef CONV_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [AW-1:0] acc_sh;
`endif

  // One stall signal freezes every stage, so a held output also blocks input.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign issue     = (row_q >= ROW_FIRST_OUT) && (col_q >= COL_FIRST_OUT);
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Column of the window entering at the current col: older rows from the line buffers, newest row live.
  always_comb begin
    for (int c = 0; c < C; c++) begin
      for (int ky = 0; ky < K - 1; ky++) col_vec[c][ky] = lb_q[c][ky][col_q];
      col_vec[c][K-1] = in_data[c*DW +: DW];
    end
  end

  always_comb begin
    for (int c = 0; c < C; c++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          prod_d[(c*K+ky)*K+kx] = PW'(win_q[c][ky][kx])
                                * PW'($signed(kernel_q[((c*K+ky)*K+kx)*DW +: DW]));
  end

  always_comb begin
    acc    = '0;
    result = '0;
    for (int i = 0; i < NTAP; i++) acc = acc + AW'(prod_q[i]);
`ifdef CONV_SATURATE_EN
    acc_sh = acc >>> FRAC_BITS;
    if (acc_sh > SAT_MAX)      result = SAT_MAX[DW-1:0];
    else if (acc_sh < SAT_MIN) result = SAT_MIN[DW-1:0];
    else                       result = acc_sh[DW-1:0];
`else
    result = DW'(acc >>> FRAC_BITS);
`endif
  end

  // Data storage carries no reset; the issue rule keeps stale contents from reaching an output.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < C; c++) begin
        for (int ky = 0; ky < K - 1; ky++) lb_q[c][ky][col_q] <= col_vec[c][ky+1];
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K - 1; kx++) win_q[c][ky][kx] <= win_q[c][ky][kx+1];
          win_q[c][ky][K-1] <= col_vec[c][ky];
        end
      end
    end
    if (advance) begin
      for (int i = 0; i < NTAP; i++) prod_q[i] <= prod_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      kernel_q    <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && col_q == '0 && row_q == '0) kernel_q <= kernel;
      if (advance) begin
        win_valid_q <= accept && issue;
        win_last_q  <= accept && frame_end;
        s1_valid_q  <= win_valid_q;
        s1_last_q   <= win_last_q;
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_last_q;
        if (s1_valid_q) out_data_q <= result;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine: a default 64x64x3 instance and a 4x4 single-channel instance.
module tb_conv_stream_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [47:0]  b_in_data;
  logic [431:0] b_kernel;
  logic [15:0]  b_out_data;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
  logic [15:0]  s_in_data;
  logic [143:0] s_kernel;
  logic [15:0]  s_out_data;

  int errors = 0;
  int checks = 0;

`ifdef CONV_SATURATE_EN
  localparam logic [15:0] EXP_CONST = 16'h7FFF;
`else
  localparam logic [15:0] EXP_CONST = 16'hD800;
`endif

  conv_stream_engine u_big (
    .clk(clk), .reset(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .kernel(b_kernel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  conv_stream_engine #(
    .DATA_WIDTH(16), .KERNEL_SIZE(3), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4), .FRAC_BITS(0)
  ) u_small (
    .clk(clk), .reset(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .kernel(s_kernel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output n of a 64x64 K=3 frame comes from pixel (2 + n/62, 2 + n%62).
  function automatic logic [15:0] exp_big(input int mode, input int n);
    int r, c;
    r = 2 + n / 62;
    c = 2 + n % 62;
    if (mode == 0) return EXP_CONST;
    return 16'((r - 1) * 64 + (c - 1));
  endfunction

  // mode 0: every channel 0x4000; mode 1: every channel = raster index.
  task automatic big_frame(input int mode, input int stall_at, input int abort_pix,
                           output int n_out, output int stall_cnt);
    int p, cyc;
    p = 0; cyc = 0; n_out = 0; stall_cnt = 0;
    while ((p < 4096 || n_out < 3844) && cyc < 6000) begin
      b_out_ready = !(cyc >= stall_at && cyc < stall_at + 10);
      b_in_valid  = (p < 4096);
      b_in_data   = (mode == 0) ? {3{16'h4000}} : {3{16'(p)}};
      #1;
      if (b_out_valid && !b_out_ready) begin
        stall_cnt++;
        check("stall_in_ready", b_in_ready, 0);
        check("stall_data_held", b_out_data, exp_big(mode, n_out));
        check("stall_last_held", b_out_last, n_out == 3843);
      end
      if (b_out_valid && b_out_ready) begin
        check("big_data", b_out_data, exp_big(mode, n_out));
        check("big_last", b_out_last, n_out == 3843);
        n_out++;
      end
      if (b_in_valid && b_in_ready) p++;
      cyc++;
      if (p == abort_pix) break;
      @(negedge clk);
    end
  endtask

  task automatic small_frame(input logic [143:0] k_first, input logic [143:0] k_after, input string tag);
    int p, n, cyc;
    logic [15:0] got [4];
    logic        lst [4];
    logic [15:0] exp_s [4];
    exp_s = '{16'd45, 16'd54, 16'd81, 16'd90};
    p = 0; n = 0; cyc = 0;
    s_out_ready = 1'b1;
    while ((p < 16 || n < 4) && cyc < 100) begin
      s_kernel   = (p == 0) ? k_first : k_after;
      s_in_valid = (p < 16);
      s_in_data  = 16'(p);
      #1;
      if (s_out_valid && s_out_ready) begin
        if (n < 4) begin got[n] = s_out_data; lst[n] = s_out_last; end
        n++;
      end
      if (s_in_valid && s_in_ready) p++;
      cyc++;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    check({tag, "_count"}, n, 4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_data"}, got[i], exp_s[i]);
      check({tag, "_last"}, lst[i], i == 3);
    end
  endtask

  initial begin
    int n, st;
    logic [143:0] k_ones, k_twos;
    for (int i = 0; i < 9; i++) begin
      k_ones[i*16 +: 16] = 16'd1;
      k_twos[i*16 +: 16] = 16'd2;
    end
    rst_n = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_kernel = '0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1; s_kernel = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", b_in_ready, 1);
    check("rst_out_valid", b_out_valid, 0);
    check("rst_out_last", b_out_last, 0);
    check("rst_out_data", b_out_data, 0);
    check("rst_small_in_ready", s_in_ready, 1);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", b_in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 27; i++) b_kernel[i*16 +: 16] = 16'h0800;
    big_frame(0, -100, -1, n, st);
    check("const_count", n, 3844);

    b_kernel = '0;
    b_kernel[4*16 +: 16] = 16'h4000;
    big_frame(1, -100, -1, n, st);
    check("ramp_count", n, 3844);

    big_frame(1, 300, -1, n, st);
    check("stall_count", n, 3844);
    check("stall_cycles", st, 10);

    big_frame(1, -100, 10*64 + 5, n, st);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check("pre_abort_valid", b_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", b_out_valid, 0);
    check("abort_in_ready", b_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_release_in_ready", b_in_ready, 1);
    @(negedge clk);
    big_frame(1, -100, -1, n, st);
    check("after_abort_count", n, 3844);

    small_frame(k_ones, k_ones, "small1");
    small_frame(k_ones, k_twos, "small2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
